// File: rtl/adc_capture_driver_pkg.sv
// Shared constants for the dual-channel ADC capture driver.
//   ADC_DATA_BITS  bits per channel sample (two's complement, MSB first)
//   ADC_FRAME_SCK  SCK periods per conversion frame
//   ADC_A_FIRST    first frame bit index carrying channel A
//   ADC_B_FIRST    first frame bit index carrying channel B
//   ST_*           FSM state encodings (2-bit)
package adc_capture_driver_pkg;

    localparam int ADC_DATA_BITS = 14;
    localparam int ADC_FRAME_SCK = 34;
    localparam int ADC_A_FIRST   = 2;
    localparam int ADC_B_FIRST   = 18;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/adc_capture_driver_spi_sck_divider.sv
// SCK generator for the ADC frame.
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   enable     in   divider runs while high; held at phase 0 otherwise
//   sck_gate   in   allows SCK to toggle (low keeps SCK low while counting)
//   sck        out  registered serial clock, low for first SCK_DIV/2 clocks
//   rise       out  high in the clock whose closing edge drives SCK 0->1
//   period_end out  high in the last clock of each SCK period
module spi_sck_divider #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sck_gate,
    output logic sck,
    output logic rise,
    output logic period_end
);

    localparam int            CW   = $clog2(SCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(SCK_DIV / 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt    = (cnt == LAST) ? '0 : cnt + CW'(1);
    assign rise       = enable && sck_gate && (cnt_nxt == HALF);
    assign period_end = enable && (cnt == LAST);

    // SCK is registered from the next phase so the pin never glitches.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sck <= sck_gate && (cnt_nxt >= HALF);
        end
    end

endmodule

// File: rtl/adc_capture_driver.sv
// Read-side SPI driver for the dual 14-bit ADC. A start strobe pulses AD_CONV
// for one SCK period, then clocks FRAME_SCK SCK periods and shifts the two
// channel samples in from SPI_MISO.
//   CLK_50M     in   system clock
//   reset       in   synchronous, active-high
//   startEnable in   1-cycle start strobe, honoured only when idle
//   SPI_MISO    in   serial data from the ADC
//   SPI_SCK     out  serial clock, idles low
//   AD_CONV     out  conversion strobe
//   Va, Vb      out  signed channel samples, updated only at frame end
//   dataValid   out  1-cycle pulse when Va/Vb update
//   busy        out  high from accepted start through the final frame clock
module adc_capture_driver
    import adc_capture_driver_pkg::*;
#(
    parameter int SCK_DIV   = 4,
    parameter int DATA_BITS = ADC_DATA_BITS,
    parameter int FRAME_SCK = ADC_FRAME_SCK
) (
    input  logic                        CLK_50M,
    input  logic                        reset,
    input  logic                        startEnable,
    input  logic                        SPI_MISO,
    output logic                        SPI_SCK,
    output logic                        AD_CONV,
    output logic signed [DATA_BITS-1:0] Va,
    output logic signed [DATA_BITS-1:0] Vb,
    output logic                        dataValid,
    output logic                        busy
);

    localparam logic [5:0] A_LO      = 6'(ADC_A_FIRST);
    localparam logic [5:0] A_HI      = 6'(ADC_A_FIRST + DATA_BITS);
    localparam logic [5:0] B_LO      = 6'(ADC_B_FIRST);
    localparam logic [5:0] B_HI      = 6'(ADC_B_FIRST + DATA_BITS);
    localparam logic [5:0] FRAME_END = 6'(FRAME_SCK);

    logic [1:0]           state;
    logic [5:0]           bit_cnt;
    logic [DATA_BITS-1:0] sh_a;
    logic [DATA_BITS-1:0] sh_b;
    logic                 div_en;
    logic                 shift_phase;
    logic                 sck_rise;
    logic                 period_end;
    logic                 a_win;
    logic                 b_win;

    // CONV runs the divider for one period with SCK suppressed, so AD_CONV
    // lasts exactly SCK_DIV clocks and SHIFT starts on a period boundary.
    assign div_en      = (state == ST_CONV) || (state == ST_SHIFT);
    assign shift_phase = (state == ST_SHIFT);
    assign AD_CONV     = (state == ST_CONV);
    assign busy        = (state != ST_IDLE);

    assign a_win = (bit_cnt >= A_LO) && (bit_cnt < A_HI);
    assign b_win = (bit_cnt >= B_LO) && (bit_cnt < B_HI);

    spi_sck_divider #(.SCK_DIV(SCK_DIV)) u_sck (
        .clk       (CLK_50M),
        .reset     (reset),
        .enable    (div_en),
        .sck_gate  (shift_phase),
        .sck       (SPI_SCK),
        .rise      (sck_rise),
        .period_end(period_end)
    );

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            Va        <= '0;
            Vb        <= '0;
            dataValid <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startEnable) state <= ST_CONV;
                end
                ST_CONV: begin
                    if (period_end) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // bit_cnt is the index of the bit being sampled at this rise
                    if (sck_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (a_win) sh_a <= {sh_a[DATA_BITS-2:0], SPI_MISO};
                        if (b_win) sh_b <= {sh_b[DATA_BITS-2:0], SPI_MISO};
                    end
                    // all rises seen and the last period has run out
                    if (period_end && (bit_cnt == FRAME_END)) state <= ST_DONE;
                end
                ST_DONE: begin
                    Va        <= sh_a;
                    Vb        <= sh_b;
                    dataValid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
